// File: rtl/instruction_fetch.sv
// Single-outstanding instruction fetch unit: issues the register-file PC to imem,
// captures the response and holds {instr, instr_pc, instr_fault} for decode.
module instruction_fetch #(
   parameter int XLEN         = 64,
   parameter int ILEN         = 32,
   parameter int IALIGN_BYTES = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            fetch_en,
   input  logic            flush,
   input  logic [XLEN-1:0] pc,
   output logic            pc_increment,
   output logic            imem_req_valid,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_req_ready,
   input  logic            imem_rsp_valid,
   input  logic [ILEN-1:0] imem_rsp_data,
   input  logic            imem_rsp_err,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic [ILEN-1:0] instr,
   output logic [XLEN-1:0] instr_pc,
   output logic [1:0]      instr_fault
);

   typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DRAIN} state_t;

   localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(IALIGN_BYTES - 1);
   localparam logic [1:0] FAULT_NONE   = 2'b00;
   localparam logic [1:0] FAULT_MISAL  = 2'b01;
   localparam logic [1:0] FAULT_ACCESS = 2'b10;

   state_t state, state_nxt;
   logic   misaligned;
   logic   cap_req, cap_mis, cap_rsp;

   assign misaligned     = |(pc & ALIGN_MASK);
   assign imem_req_valid = (state == REQ) && !misaligned;
   assign imem_req_addr  = imem_req_valid ? pc : '0;
   assign instr_valid    = (state == HOLD);

   always_comb begin
      state_nxt = state;
      cap_req   = 1'b0;
      cap_mis   = 1'b0;
      cap_rsp   = 1'b0;
      case (state)
         IDLE: if (fetch_en && !flush) state_nxt = REQ;
         REQ: begin
            // a request accepted in the flush cycle is still outstanding and must be drained
            if (flush) begin
               state_nxt = (!misaligned && imem_req_ready) ? DRAIN : IDLE;
            end else if (misaligned) begin
               state_nxt = HOLD;
               cap_mis   = 1'b1;
            end else if (imem_req_ready) begin
               state_nxt = WAIT;
               cap_req   = 1'b1;
            end
         end
         WAIT: begin
            if (flush) begin
               state_nxt = imem_rsp_valid ? IDLE : DRAIN;
            end else if (imem_rsp_valid) begin
               state_nxt = HOLD;
               cap_rsp   = 1'b1;
            end
         end
         HOLD: begin
            if (flush)            state_nxt = IDLE;
            else if (instr_ready) state_nxt = fetch_en ? REQ : IDLE;
         end
         DRAIN: if (imem_rsp_valid) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state        <= IDLE;
         pc_increment <= 1'b0;
         instr        <= '0;
         instr_pc     <= '0;
         instr_fault  <= FAULT_NONE;
      end else begin
         state        <= state_nxt;
         // pulse lands in the first HOLD cycle, so the PC moves before the next REQ
         pc_increment <= cap_rsp && !imem_rsp_err;
         if (cap_mis) begin
            instr       <= '0;
            instr_pc    <= pc;
            instr_fault <= FAULT_MISAL;
         end
         if (cap_req) instr_pc <= pc;
         if (cap_rsp) begin
            instr       <= imem_rsp_err ? '0 : imem_rsp_data;
            instr_fault <= imem_rsp_err ? FAULT_ACCESS : FAULT_NONE;
         end
      end
   end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: table-driven single fetches, hand-written flush/reset
// sequences, then randomized traffic against a transaction-level reference model.
module tb_instruction_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        fetch_en;
   logic        flush;
   logic [63:0] pc;
   logic        pc_increment;
   logic        imem_req_valid;
   logic [63:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        imem_rsp_err;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [63:0] instr_pc;
   logic [1:0]  instr_fault;

   int checks = 0;
   int errors = 0;

   instruction_fetch #(.XLEN(64), .ILEN(32), .IALIGN_BYTES(4)) dut (
      .clk(clk), .rst(rst), .fetch_en(fetch_en), .flush(flush), .pc(pc),
      .pc_increment(pc_increment), .imem_req_valid(imem_req_valid),
      .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .imem_rsp_err(imem_rsp_err), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr(instr), .instr_pc(instr_pc), .instr_fault(instr_fault)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] pc;
      logic [31:0] data;
      logic        err;
      int          rdy_dly;
      int          rsp_dly;
      int          hold;
      logic [31:0] exp_instr;
      logic [1:0]  exp_fault;
      logic        exp_inc;
   } vec_t;

   typedef struct packed {
      logic [31:0] instr;
      logic [63:0] pc;
      logic [1:0]  fault;
   } item_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // inputs are driven 2 time units after the rising edge, outputs read 1 unit later
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_req_valid"}, imem_req_valid, 0);
      chk({tag, "_req_addr"}, imem_req_addr, 0);
      chk({tag, "_pc_inc"}, pc_increment, 0);
      chk({tag, "_instr_valid"}, instr_valid, 0);
      chk({tag, "_instr"}, instr, 0);
      chk({tag, "_instr_pc"}, instr_pc, 0);
      chk({tag, "_fault"}, instr_fault, 0);
   endtask

   task automatic do_vec(input vec_t v);
      int   n;
      logic saw_req;
      pc = v.pc; fetch_en = 1'b1; flush = 1'b0; instr_ready = 1'b0;
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
      #1;
      if (v.exp_fault == 2'b01) begin
         saw_req = 1'b0;
         n = 0;
         while (!instr_valid && n < 8) begin
            saw_req |= imem_req_valid;
            tick(); #1; n++;
         end
         chk("vec_misal_no_req", saw_req, 0);
      end else begin
         n = 0;
         while (!imem_req_valid && n < 8) begin tick(); #1; n++; end
         chk("vec_req_valid", imem_req_valid, 1);
         for (int i = 0; i < v.rdy_dly; i++) begin
            tick(); #1;
            chk("vec_req_stall_valid", imem_req_valid, 1);
            chk("vec_req_stall_addr", imem_req_addr, v.pc);
         end
         chk("vec_req_addr", imem_req_addr, v.pc);
         imem_req_ready = 1'b1;
         tick();
         imem_req_ready = 1'b0;
         for (int i = 0; i < v.rsp_dly; i++) begin
            #1;
            chk("vec_wait_no_valid", instr_valid, 0);
            tick();
         end
         imem_rsp_valid = 1'b1; imem_rsp_data = v.data; imem_rsp_err = v.err;
         tick();
         imem_rsp_valid = 1'b0; imem_rsp_data = $urandom; imem_rsp_err = 1'b0;
      end
      #1;
      chk("vec_instr_valid", instr_valid, 1);
      chk("vec_instr", instr, v.exp_instr);
      chk("vec_instr_pc", instr_pc, v.pc);
      chk("vec_fault", instr_fault, v.exp_fault);
      chk("vec_pc_inc", pc_increment, v.exp_inc);
      for (int i = 0; i < v.hold; i++) begin
         tick(); #1;
         chk("vec_hold_valid", instr_valid, 1);
         chk("vec_hold_instr", instr, v.exp_instr);
         chk("vec_hold_pc", instr_pc, v.pc);
         chk("vec_hold_no_inc", pc_increment, 0);
      end
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
   endtask

   vec_t vecs[7];

   // reference-model state for the randomized phase
   item_t       q[$];
   logic        outstanding, dropped, exp_inc, inc_seen, redir_pend;
   logic [63:0] pend_addr, redir_tgt;
   int          rsp_cnt;
   item_t       it;

   function automatic logic [63:0] rand_target(input logic allow_misal);
      logic [63:0] t;
      t = 64'h8000_0000 + 64'(($urandom % 4096) * 4);
      if (allow_misal && ($urandom % 6 == 0)) t = t + 64'd2;
      return t;
   endfunction

   initial begin
      vecs[0] = '{64'h8000_0000, 32'h0000_0013, 1'b0, 0, 0, 0, 32'h0000_0013, 2'b00, 1'b1};
      vecs[1] = '{64'h8000_0002, 32'h0,         1'b0, 0, 0, 0, 32'h0,         2'b01, 1'b0};
      vecs[2] = '{64'h8000_0010, 32'h1234_5678, 1'b1, 5, 1, 0, 32'h0,         2'b10, 1'b0};
      vecs[3] = '{64'h8000_0004, 32'h00a0_0093, 1'b0, 2, 3, 4, 32'h00a0_0093, 2'b00, 1'b1};
      vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFF_FFFF, 1'b0, 0, 0, 1, 32'hFFFF_FFFF, 2'b00, 1'b1};
      vecs[5] = '{64'h0000_0000_0000_0001, 32'h0, 1'b0, 0, 0, 2, 32'h0, 2'b01, 1'b0};
      vecs[6] = '{64'h0, 32'h0, 1'b0, 1, 0, 0, 32'h0, 2'b00, 1'b1};

      rst = 1'b0; fetch_en = 1'b0; flush = 1'b0; pc = '0; imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0; imem_rsp_data = '0; imem_rsp_err = 1'b0; instr_ready = 1'b0;
      tick(); tick(); #1;
      chk_idle_outputs("reset");
      rst = 1'b1;

      foreach (vecs[i]) do_vec(vecs[i]);

      // flush in WAIT: late response is drained, next fetch uses the redirected PC
      pc = 64'h8000_0100; fetch_en = 1'b1; #1;
      for (int n = 0; n < 8 && !imem_req_valid; n++) begin tick(); #1; end
      chk("flw_req_addr", imem_req_addr, 64'h8000_0100);
      imem_req_ready = 1'b1; tick(); imem_req_ready = 1'b0;
      flush = 1'b1; #1;
      chk("flw_no_valid", instr_valid, 0);
      tick(); flush = 1'b0; pc = 64'h8000_0200; #1;
      chk("flw_drain_no_req", imem_req_valid, 0);
      tick();
      imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF; #1;
      chk("flw_drain_no_req2", imem_req_valid, 0);
      tick(); imem_rsp_valid = 1'b0; #1;
      chk("flw_dropped_valid", instr_valid, 0);
      chk("flw_dropped_inc", pc_increment, 0);
      chk("flw_idle_no_req", imem_req_valid, 0);
      tick(); #1;
      chk("flw_redirect_valid", imem_req_valid, 1);
      chk("flw_redirect_addr", imem_req_addr, 64'h8000_0200);
      imem_req_ready = 1'b1; tick(); imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0513; tick(); imem_rsp_valid = 1'b0; #1;
      chk("flw_new_valid", instr_valid, 1);
      chk("flw_new_instr", instr, 32'h0000_0513);
      chk("flw_new_pc", instr_pc, 64'h8000_0200);
      chk("flw_new_inc", pc_increment, 1);

      // flush together with instr_ready in HOLD: item dropped, back to IDLE
      pc = 64'h8000_0300; flush = 1'b1; instr_ready = 1'b1;
      tick(); flush = 1'b0; instr_ready = 1'b0; #1;
      chk("hflush_valid", instr_valid, 0);
      chk("hflush_idle_no_req", imem_req_valid, 0);
      chk("hflush_inc", pc_increment, 0);
      tick(); #1;
      chk("hflush_next_req", imem_req_valid, 1);
      chk("hflush_next_addr", imem_req_addr, 64'h8000_0300);

      // reset while WAITing: outputs cleared, stale response ignored
      imem_req_ready = 1'b1; tick(); imem_req_ready = 1'b0;
      rst = 1'b0; fetch_en = 1'b0; tick(); rst = 1'b1; #1;
      chk_idle_outputs("rstwait");
      imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0BAD_C0DE;
      tick(); imem_rsp_valid = 1'b0; #1;
      chk("rstwait_late_valid", instr_valid, 0);
      chk("rstwait_late_inc", pc_increment, 0);
      chk("rstwait_late_instr", instr, 0);
      tick(); #1;
      chk("rstwait_late_valid2", instr_valid, 0);

      // randomized traffic against the transaction-level model
      pc = 64'h8000_0000;
      outstanding = 1'b0; dropped = 1'b0; exp_inc = 1'b0; inc_seen = 1'b0;
      redir_pend = 1'b0; redir_tgt = '0; pend_addr = '0; rsp_cnt = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         tick();
         if (redir_pend) pc = redir_tgt;
         else if (inc_seen) pc = pc + 64'd4;
         redir_pend = 1'b0;
         fetch_en       = ($urandom % 8) != 0;
         flush          = ($urandom % 20) == 0;
         instr_ready    = ($urandom % 3) != 0;
         imem_req_ready = ($urandom % 3) != 0;
         imem_rsp_valid = outstanding && (rsp_cnt == 0);
         imem_rsp_data  = $urandom;
         imem_rsp_err   = imem_rsp_valid && (($urandom % 6) == 0);
         #1;
         chk("rnd_pc_inc", pc_increment, exp_inc);
         if (q.size() > 0) begin
            chk("rnd_valid", instr_valid, 1);
            chk("rnd_instr", instr, q[0].instr);
            chk("rnd_instr_pc", instr_pc, q[0].pc);
            chk("rnd_fault", instr_fault, q[0].fault);
         end else if (instr_valid) begin
            chk("rnd_misal_fault", instr_fault, 2'b01);
            chk("rnd_misal_instr", instr, 0);
            chk("rnd_misal_pc", instr_pc, pc);
            chk("rnd_misal_pc_odd", pc[1:0] != 2'b00, 1);
         end
         if (imem_req_valid) begin
            chk("rnd_req_addr", imem_req_addr, pc);
            chk("rnd_req_aligned", pc[1:0], 0);
            chk("rnd_single_outstanding", outstanding, 0);
         end
         // advance the model with this cycle's events
         inc_seen = pc_increment;
         exp_inc  = 1'b0;
         if (outstanding && flush) dropped = 1'b1;
         if (imem_rsp_valid) begin
            outstanding = 1'b0;
            if (!dropped) begin
               it.instr = imem_rsp_err ? 32'h0 : imem_rsp_data;
               it.pc    = pend_addr;
               it.fault = imem_rsp_err ? 2'b10 : 2'b00;
               q.push_back(it);
               exp_inc = !imem_rsp_err;
            end
         end else if (outstanding) begin
            rsp_cnt--;
         end
         if (imem_req_valid && imem_req_ready) begin
            outstanding = 1'b1;
            dropped     = flush;
            pend_addr   = pc;
            rsp_cnt     = $urandom % 4;
         end
         if (instr_valid && (flush || instr_ready)) begin
            if (!flush && (instr_fault != 2'b00)) begin
               redir_pend = 1'b1;
               redir_tgt  = rand_target(1'b0);
            end
            if (q.size() > 0) void'(q.pop_front());
         end
         if (flush) begin
            redir_pend = 1'b1;
            redir_tgt  = rand_target(1'b1);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
